// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Multi-cycle multiply / divide controller for the EXE stage.
//             Multiply completes after MUL_LAT cycles. Divide is a radix-2
//             restoring divider: 32 iterations followed by a sign fixup.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [1:0]  ext_op_in,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        finish,
  output logic [1:0]  ext_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] C_MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] C_DIV_CNT = 6'd32;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic [1:0]  r_ext_op;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;

  logic        w_accept;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_op_a;
  logic [63:0] w_op_b;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_accept = (r_state == IDLE) && start && !flush;

  // Operand magnitudes feed the divider; unsigned operands pass through.
  assign w_a_mag = (is_signed && src_a[31]) ? -src_a : src_a;
  assign w_b_mag = (is_signed && src_b[31]) ? -src_b : src_b;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign w_op_a = {{32{r_signed & r_a[31]}}, r_a};
  assign w_op_b = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_op_a * w_op_b;

  // One restoring-divide step. When the trial subtraction succeeds the
  // remainder is below the divisor, so the 32-bit modular difference is exact.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_sub   = w_shift[31:0] - r_dvs;

  assign w_a_neg    = r_signed & r_a[31];
  assign w_b_neg    = r_signed & r_b[31];
  assign w_quot_fix = (w_a_neg ^ w_b_neg) ? -r_quot : r_quot;
  assign w_rem_fix  = w_a_neg ? -r_rem : r_rem;

  assign finish = (r_state == DONE) && !flush;
  assign stall  = start && !finish;
  assign ext_op = r_ext_op;
  assign res_hi = r_res_hi;
  assign res_lo = r_res_lo;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; a flush abandons any running operation.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = is_div ? DIV : MUL;
      MUL: begin
        if (flush)              w_state_nxt = IDLE;
        else if (r_cnt == 6'd1) w_state_nxt = DONE;
      end
      DIV: begin
        if (flush)              w_state_nxt = IDLE;
        else if (r_cnt == 6'd0) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration counter, divider datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 6'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_ext_op <= 2'b00;
      r_quot   <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= is_signed;
            r_ext_op <= is_div ? 2'b00 : ext_op_in;
            r_cnt    <= is_div ? C_DIV_CNT : C_MUL_CNT;
            r_quot   <= w_a_mag;
            r_rem    <= 32'd0;
            r_dvs    <= w_b_mag;
          end
        end
        MUL: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_res_hi <= w_prod[63:32];
            r_res_lo <= w_prod[31:0];
          end
        end
        DIV: begin
          if (r_cnt != 6'd0) begin
            r_cnt  <= r_cnt - 6'd1;
            r_rem  <= w_ge ? w_sub : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
          end else if (r_b == 32'd0) begin
            r_res_hi <= r_a;
            r_res_lo <= 32'hFFFF_FFFF;
          end else begin
            r_res_hi <= w_rem_fix;
            r_res_lo <= w_quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Scoreboard bench for muldiv_ctrl: expected HI/LO/ext_op and
//             finish cycle are queued at issue and compared on each finish.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_div;
  logic        is_signed;
  logic [1:0]  ext_op_in;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        finish;
  logic [1:0]  ext_op;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  ext;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_fin    = 0;
  logic [31:0] cyc      = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (is_div),
    .is_signed (is_signed),
    .ext_op_in (ext_op_in),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall     (stall),
    .finish    (finish),
    .ext_op    (ext_op),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: results computed with plain 64-bit arithmetic.
  function automatic exp_t model(input logic dv, input logic sg, input logic [1:0] ex,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, q, r;
    logic [63:0] p;
    e.ext = dv ? 2'b00 : ex;
    e.cyc = cyc + (dv ? 32'd34 : 32'(MUL_LAT));
    if (!dv) begin
      if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else    p = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else if (sg) begin
      sa   = longint'($signed(a));
      sbv  = longint'($signed(b));
      q    = sa / sbv;
      r    = sa % sbv;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Scoreboard monitor: every finish pulse pops and checks one expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst && finish) begin
      n_fin++;
      if (sb.size() == 0) begin
        check("unexpected_finish", {63'd0, finish}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("finish_cycle", {32'd0, cyc}, {32'd0, e.cyc});
        check("res_hi", {32'd0, res_hi}, {32'd0, e.hi});
        check("res_lo", {32'd0, res_lo}, {32'd0, e.lo});
        check("ext_op", {62'd0, ext_op}, {62'd0, e.ext});
      end
    end
  end

  task automatic drive(input logic dv, input logic sg, input logic [1:0] ex,
                       input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_div    = dv;
    is_signed = sg;
    ext_op_in = ex;
    src_a     = a;
    src_b     = b;
  endtask

  // Waits (bounded) for finish while checking stall, then confirms DONE
  // lasts a single cycle even though start is still high.
  task automatic wait_fin();
    int got = 0;
    int bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        got = 1;
        break;
      end
      if (stall !== 1'b1) bad++;
    end
    check("finish_seen", 64'(got), 64'd1);
    check("stall_running", 64'(bad), 64'd0);
    if (got != 0) check("stall_at_finish", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'd0, finish}, 64'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic dv, input logic sg, input logic [1:0] ex,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(dv, sg, ex, a, b);
    sb.push_back(model(dv, sg, ex, a, b));
    #1;
    check("stall_cycle0", {63'd0, stall}, 64'd1);
    wait_fin();
  endtask

  initial begin
    int f0;
    rst = 1'b0; start = 1'b0; is_div = 1'b0; is_signed = 1'b0;
    ext_op_in = 2'b00; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_finish", {63'd0, finish}, 64'd0);
    check("rst_ext_op", {62'd0, ext_op}, 64'd0);
    check("rst_res_hi", {32'd0, res_hi}, 64'd0);
    check("rst_res_lo", {32'd0, res_lo}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    rst = 1'b1;

    do_op(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3);
    do_op(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'd3);
    do_op(1'b1, 1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op(1'b1, 1'b0, 2'b00, 32'd100, 32'd0);
    do_op(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFB, 32'd0);
    do_op(1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd7);
    do_op(1'b1, 1'b1, 2'b01, 32'd7, 32'hFFFF_FFFE);
    do_op(1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++)
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : $urandom);

    // Flush in cycle 10 of a divide, then a MADD issued in cycle 12.
    f0 = n_fin;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    do_op(1'b0, 1'b0, 2'b01, 32'd12345, 32'd678);
    repeat (30) @(negedge clk);
    check("flush_div_finishes", 64'(n_fin - f0), 64'd1);

    // Flush in the DONE cycle suppresses the pulse.
    f0 = n_fin;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'd5, 32'd6);
    repeat (MUL_LAT) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_in_done", {63'd0, finish}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_done_finishes", 64'(n_fin - f0), 64'd0);

    // Flush together with start in IDLE is not accepted.
    f0 = n_fin;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'd9, 32'd9);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_idle_finishes", 64'(n_fin - f0), 64'd0);

    // Reset pulse in cycle 2 of a multiply; start held, re-accepted in cycle 3.
    f0 = n_fin;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 32'hFFFF_FFF0, 32'd7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_finish", {63'd0, finish}, 64'd0);
    check("rst_mid_res_lo", {32'd0, res_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(model(1'b0, 1'b1, 2'b00, 32'hFFFF_FFF0, 32'd7));
    wait_fin();
    repeat (20) @(negedge clk);
    check("rst_mid_finishes", 64'(n_fin - f0), 64'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 4: multiply latency in cycles, legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: EXE holds a mult/div instruction; held high until finish.
REQ-005 The block SHALL have port is_div, input, 1: 1 = divide, 0 = multiply.
REQ-006 The block SHALL have port is_signed, input, 1: 1 = signed operands, 0 = unsigned operands.
REQ-007 The block SHALL have port ext_op_in, input, 2: 00 = plain, 01 = MADD, 10 = MSUB; ignored when is_div=1.
REQ-008 The block SHALL have port src_a, input, 32: multiplicand or dividend.
REQ-009 The block SHALL have port src_b, input, 32: multiplier or divisor.
REQ-010 The block SHALL have port flush, input, 1: exception or pipeline flush; aborts the operation in progress.
REQ-011 The block SHALL have port stall, output, 1: freezes IF..EXE while the operation runs.
REQ-012 The block SHALL have port finish, output, 1: one-cycle pulse that writes HI/LO.
REQ-013 The block SHALL have port ext_op, output, 2: registered copy of ext_op_in, forced to 00 for divides.
REQ-014 The block SHALL have port res_hi, output, 32: HI result (product[63:32] or remainder).
REQ-015 The block SHALL have port res_lo, output, 32: LO result (product[31:0] or quotient).

Function
REQ-016 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-017 IDLE SHALL go to MUL (is_div=0) or DIV (is_div=1) when start=1 and flush=0; that cycle is the acceptance cycle (cycle 0).
REQ-018 On acceptance, the block SHALL latch operands, is_signed and ext_op_in.
REQ-019 MUL SHALL count down from MUL_LAT-1 and go to DONE when the count reaches 0, so finish is high in cycle MUL_LAT.
REQ-020 Multiply SHALL produce the 64-bit product: signed two's-complement product when is_signed=1, else unsigned.
REQ-021 DIV SHALL run a radix-2 restoring divide on operand magnitudes, 32 iterations in cycles 1..32 plus a sign fixup in cycle 33, and go to DONE so finish is high in cycle 34.
REQ-022 Signed divide SHALL give quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
REQ-023 Divide with src_b=0 SHALL give res_lo=0xFFFFFFFF and res_hi=src_a, with the same latency of 34.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give res_lo=0x80000000 and res_hi=0.
REQ-025 DONE SHALL hold for exactly one cycle, assert finish=1, and go to IDLE unconditionally, even if start is still high.
REQ-026 stall SHALL equal start AND NOT finish: high combinationally in cycle 0 and low in the finish cycle.
REQ-027 res_hi, res_lo and ext_op SHALL be registered and stable while finish=1; their values outside DONE are don't-care.
REQ-028 flush=1 in MUL or DIV SHALL force IDLE on the next edge with no finish pulse.
REQ-029 flush=1 in DONE SHALL suppress finish in that cycle (finish = DONE AND NOT flush).
REQ-030 flush=1 together with start in IDLE SHALL NOT accept the request.
REQ-031 start falling in MUL or DIV without flush is illegal; the block SHALL still complete and pulse finish.

Reset
REQ-032 While rst=0, the block SHALL hold state=IDLE, counter=0, finish=0, ext_op=00, res_hi=0 and res_lo=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation immediately, with no finish pulse after release.

Verification
REQ-034 MULT a=0xFFFFFFFE, b=3, signed, MUL_LAT=4 -> finish in cycle 4 with res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA; stall high in cycles 0..3.
REQ-035 MULTU with the same operands -> res_hi=0x00000002, res_lo=0xFFFFFFFA.
REQ-036 DIV a=-7 (0xFFFFFFF9), b=2, signed -> finish in cycle 34 with res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
REQ-037 DIVU a=100, b=0 -> cycle 34 with res_lo=0xFFFFFFFF, res_hi=100.
REQ-038 flush at cycle 10 of a DIV -> no finish, IDLE in cycle 11; a new MADD issued in cycle 12 finishes in cycle 12+MUL_LAT with ext_op=01.
REQ-039 rst low in cycle 2 of a MUL, high again in cycle 3, start held -> new acceptance in cycle 3 and exactly one finish, in cycle 3+MUL_LAT.
